// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter sharing a single register-file RAM port.
// Round-robin on conflict, with optional locked bursts capped at BURST_MAX.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 16,
    parameter int BURST_MAX  = 4
) (
    input  logic                  clk,
    input  logic                  res_n,
    input  logic [1:0]            req,
    input  logic [1:0]            we,
    input  logic [1:0]            lock,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic [1:0]            gnt,
    output logic [1:0]            rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_ren,
    output logic                  ram_wen,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

    state_e     state, state_nxt;
    logic       last_gnt, last_gnt_nxt;
    logic [3:0] burst_cnt, burst_cnt_nxt;
    logic [1:0] rd_pend;
    logic [1:0] gnt_int;
    logic       do_arb, arb_last, owner, other, win;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        gnt_int       = 2'b00;
        state_nxt     = state;
        last_gnt_nxt  = last_gnt;
        burst_cnt_nxt = burst_cnt;
        do_arb        = 1'b0;
        arb_last      = last_gnt;
        owner         = (state == OWN1);
        other         = ~owner;
        win           = 1'b0;

        if (state == IDLE) begin
            do_arb = 1'b1;
        end else if (req[owner] && lock[owner] &&
                     (burst_cnt < BURST_LIM || !req[other])) begin
            gnt_int[owner] = 1'b1;
            burst_cnt_nxt  = (burst_cnt == 4'hF) ? burst_cnt : burst_cnt + 4'd1;
        end else if (req[owner] && !lock[owner]) begin
            gnt_int[owner] = 1'b1;
            state_nxt      = IDLE;
            last_gnt_nxt   = owner;
            burst_cnt_nxt  = 4'd0;
        end else begin
            // Ownership released: arbitrate in the same cycle so the other side sees no bubble.
            do_arb   = 1'b1;
            arb_last = owner;
        end

        if (do_arb) begin
            state_nxt     = IDLE;
            last_gnt_nxt  = arb_last;
            burst_cnt_nxt = 4'd0;
            win           = (req == 2'b11) ? ~arb_last : req[1];
            if (|req) begin
                gnt_int[win] = 1'b1;
                last_gnt_nxt = win;
                if (lock[win]) begin
                    state_nxt     = win ? OWN1 : OWN0;
                    burst_cnt_nxt = 4'd1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            burst_cnt <= 4'd0;
            rd_pend   <= 2'b00;
        end else begin
            state     <= state_nxt;
            last_gnt  <= last_gnt_nxt;
            burst_cnt <= burst_cnt_nxt;
            rd_pend   <= gnt_int & ~we;
        end
    end

    // Grants are masked while reset is asserted so nothing reaches the RAM.
    assign gnt       = res_n ? gnt_int : 2'b00;
    assign ram_ren   = |(gnt & ~we);
    assign ram_wen   = |(gnt & we);
    assign ram_addr  = gnt[0] ? addr0  : (gnt[1] ? addr1  : '0);
    assign ram_wdata = gnt[0] ? wdata0 : (gnt[1] ? wdata1 : '0);
    assign rvalid    = rd_pend;
    assign rdata     = (|rd_pend) ? ram_rdata : '0;

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, RAM word-address width.
REQ-002 Parameter DATA_WIDTH, default 16, RAM data width.
REQ-003 Parameter BURST_MAX, default 4, maximum consecutive locked grants while the other requester waits; legal range 1..15.
REQ-004 Ports SHALL be exactly:
  clk  input  1  single clock; all state on rising edge
  res_n  input  1  reset, asynchronous, active-low
  req  input  2  access request, bit i = requester i
  we  input  2  1 = write, 0 = read, per requester
  lock  input  2  requester asks to keep ownership after this access
  addr0, addr1  input  ADDR_WIDTH  word address per requester
  wdata0, wdata1  input  DATA_WIDTH  write data per requester
  gnt  output  2  access accepted this cycle, one-hot or zero
  rvalid  output  2  read data valid for requester i
  rdata  output  DATA_WIDTH  shared read-return bus
  ram_addr  output  ADDR_WIDTH  to the register-file RAM hardware port addr
  ram_ren  output  1  to RAM port ren
  ram_wen  output  1  to RAM port wen
  ram_wdata  output  DATA_WIDTH  to RAM port wdata
  ram_rdata  input  DATA_WIDTH  from RAM port rdata, valid one cycle after ren

Function
REQ-005 The block SHALL share one RAM hardware port between two requesters, issuing at most one access per cycle.
REQ-006 gnt SHALL be combinational from req and registered state; a granted access is driven onto the ram_* outputs in the same cycle (zero-latency issue).
REQ-007 ram_ren = gnt[i] & ~we[i]; ram_wen = gnt[i] & we[i]; ram_addr/ram_wdata = selected requester's addr/wdata; with no grant, ram_addr = 0, ram_wdata = 0, ram_ren = ram_wen = 0.
REQ-008 Registered state: state in {IDLE, OWN0, OWN1}, last_gnt (1 bit), burst_cnt (4 bits).
REQ-009 IDLE, single req: grant it; both req: grant requester != last_gnt (round-robin).
REQ-010 On any grant to i: last_gnt <= i; if lock[i] next state OWNi with burst_cnt <= 1, else IDLE.
REQ-011 OWNi, req[i] & lock[i] & (burst_cnt < BURST_MAX or ~req[other]): grant i, burst_cnt increments saturating at 15, stay OWNi.
REQ-012 OWNi, req[i] without lock[i]: grant i, return to IDLE.
REQ-013 OWNi, ~req[i], or burst_cnt == BURST_MAX with req[other]: ownership released; same-cycle IDLE arbitration with last_gnt = i, so the other requester is granted in that cycle if requesting (no bubble).
REQ-014 rvalid[i] SHALL assert exactly one cycle after a read grant to i, for one cycle per read; back-to-back reads give back-to-back rvalid.
REQ-015 rdata = ram_rdata when any rvalid bit is set, else 0.
REQ-016 Writes produce no rvalid; a write in the cycle after a read does not disturb that read's rvalid/rdata.
REQ-017 Requests are level-based; an ungranted requester holds req, we, addr, wdata stable until granted.

Reset
REQ-018 res_n low SHALL asynchronously force state = IDLE, last_gnt = 1 (requester 0 wins the first conflict), burst_cnt = 0, pending read-return flags = 0.
REQ-019 During reset gnt, rvalid, rdata, ram_addr, ram_ren, ram_wen, ram_wdata SHALL all be 0; a read granted the cycle before reset assertion produces no rvalid.
REQ-020 First grant possible in the first cycle with res_n high.

Verification
REQ-021 Single requester: req0 read addr0=3 with RAM word 3 = 0x0023 -> gnt=01, ram_ren=1, ram_addr=3 same cycle; next cycle rvalid=01, rdata=0x0023.
REQ-022 Conflict after reset: req=11, no lock, held 4 cycles -> gnt sequence 01,10,01,10.
REQ-023 Burst cap: BURST_MAX=4, requester 1 locked reads, requester 0 requesting from the start -> gnt=10 for 4 cycles, then 01 in cycle 5 with no idle cycle.
REQ-024 Uncontended lock: requester 0 locked for 20 cycles, req1=0 -> gnt=01 all 20 cycles, burst_cnt saturates at 15, no idle cycles.
REQ-025 Interleave: requester 0 writes addr 0..31 with data i while requester 1 reads addr 0..31 -> alternating grants, every read returns the last value written to that address, one rvalid per read.
REQ-026 Reset mid-operation: res_n low in the cycle after a read grant -> rvalid, gnt, ram_ren immediately 0, no rvalid after release; first post-reset conflict grants requester 0.
